adder_share_arb: RTL and testbench



---
 rtl/adder_share_pkg.sv | 26 ++
 rtl/adder_share_arb_rr_arbiter.sv | 33 +++
 rtl/adder_share_arb.sv | 118 +++++++++++
 tb/tb_adder_share_arb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared definitions for the arbitrated adder: op encodings and op decode.
package adder_share_pkg;

  localparam logic [1:0] OP_PASS_A = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_PASS_B = 2'b10;

  typedef struct packed {
    logic add_sel;
    logic pass_b_sel;
  } op_sel_t;

  // 2'b11 aliases PASS_B: the pass-B select wins over the add select in the mux
  function automatic op_sel_t decode_op(input logic [1:0] op);
    op_sel_t sel;
    sel = '0;
    case (op)
      OP_PASS_A:        sel = '0;
      OP_ADD:           sel.add_sel = 1'b1;
      OP_PASS_B, 2'b11: sel.pass_b_sel = 1'b1;
      default:          sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  int   idx;
  logic found;
  logic hit;

  // Rotating search; the found flag keeps the grant one-hot
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    hit     = 1'b0;
    idx     = 0;
    for (int k = 0; k < R; k++) begin
      idx      = (int'(ptr) + k) % R;
      hit      = en && !found && req[idx];
      gnt[idx] = gnt[idx] | hit;
      gnt_idx  = hit ? IDW'(idx) : gnt_idx;
      found    = found | hit;
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sharing of one adder/pass datapath among R requesters,
// with a single tagged result slot drained by a valid/ready consumer.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int N   = 32,
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R*2-1:0] req_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_carry
);

  logic [R-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic           slot_free;
  logic           transfer;

  logic [N-1:0]   opa;
  logic [N-1:0]   opb;
  logic [1:0]     op;
  op_sel_t        sel;
  logic [N:0]     sum;
  logic [N-1:0]   res_data;
  logic           res_carry;

  logic           rsp_valid_q, rsp_valid_d;
  logic [N-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // A slot being drained this cycle may be refilled on the same edge
  assign slot_free = !rsp_valid_q || rsp_ready;

  rr_arbiter #(
    .R   (R),
    .IDW (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (slot_free),
    .gnt     (grant),
    .gnt_idx (grant_idx)
  );

  assign transfer  = |grant;
  assign req_ready = grant;

  always_comb begin
    opa = req_a[int'(grant_idx)*N +: N];
    opb = req_b[int'(grant_idx)*N +: N];
    op  = req_op[int'(grant_idx)*2 +: 2];
    sel = decode_op(op);
    sum = {1'b0, opa} + {1'b0, opb};
    if (sel.pass_b_sel) begin
      res_data  = opb;
      res_carry = 1'b0;
    end else if (sel.add_sel) begin
      res_data  = sum[N-1:0];
      res_carry = sum[N];
    end else begin
      res_data  = opa;
      res_carry = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_carry_d = rsp_carry_q;
    rr_ptr_d    = rr_ptr_q;
    if (transfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = res_data;
      rsp_id_d    = grant_idx;
      rsp_carry_d = res_carry;
      rr_ptr_d    = (grant_idx == IDW'(R - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_carry_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_carry_q <= rsp_carry_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Scenario bench for adder_share_arb: reference grant/result model feeding a result queue.
module tb_adder_share_arb;

  localparam int N   = 32;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R*2-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_data;
  logic [IDW-1:0] rsp_id;
  logic           rsp_carry;

  typedef struct {
    logic [N-1:0]   data;
    logic [IDW-1:0] id;
    logic           carry;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           m_ptr  = 0;
  bit           m_valid = 1'b0;
  logic [R-1:0] m_g;
  int           m_gidx;
  logic [N-1:0] ops_tbl [4];

  adder_share_arb #(.N(N), .R(R), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_carry (rsp_carry)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [R-1:0] model_grant(input logic [R-1:0] v, input int ptr, input bit free);
    logic [R-1:0] g;
    int i;
    g = '0;
    if (free) begin
      for (int k = 0; k < R; k++) begin
        i = (ptr + k) % R;
        if (v[i]) begin
          g[i] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  function automatic logic [N:0] model_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a};
      2'b01:   return {1'b0, a} + {1'b0, b};
      default: return {1'b0, b};
    endcase
  endfunction

  task automatic set_req(input int k, input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
    req_valid[k]       = v;
    req_a[k*N +: N]    = a;
    req_b[k*N +: N]    = b;
    req_op[k*2 +: 2]   = op;
  endtask

  // Predict this cycle's grant at the falling edge and queue the result it will produce
  task automatic predict();
    logic [N:0] r;
    exp_t       e;
    @(negedge clk);
    m_g    = model_grant(req_valid, m_ptr, !m_valid || rsp_ready);
    m_gidx = -1;
    for (int k = 0; k < R; k++) begin
      if (m_g[k]) begin
        m_gidx  = k;
        r       = model_op(req_a[k*N +: N], req_b[k*N +: N], req_op[k*2 +: 2]);
        e.data  = r[N-1:0];
        e.id    = IDW'(k);
        e.carry = r[N];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_valid && rsp_ready) void'(exp_q.pop_front());
    if (m_gidx >= 0) begin
      m_valid = 1'b1;
      m_ptr   = (m_gidx + 1) % R;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", rsp_carry); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0; m_ptr = 0; m_valid = 1'b0; exp_q.delete();
  endtask

  task automatic test_first_add();
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'b01);
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      predict();
      if (c == 0) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL first_grant: got %b want 0100", req_ready); end
      end
      if (c == 1) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_carry !== 1'b1 || rsp_id !== 2'd2) begin
          errors++; $display("FAIL first_add_result: got v=%b d=%h c=%b id=%0d want v=1 d=0 c=1 id=2", rsp_valid, rsp_data, rsp_carry, rsp_id);
        end
      end
      checks++; if (req_ready !== m_g) begin errors++; $display("FAIL first_ready: got %b want %b", req_ready, m_g); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL first_valid: got %b want %b", rsp_valid, m_valid); end
      advance();
      req_valid = '0;
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < R; k++) set_req(k, 1'b1, $urandom(), $urandom(), 2'($urandom_range(0, 3)));
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 14) req_valid = '0;
      predict();
      checks++; if (req_ready !== m_g) begin errors++; $display("FAIL rr_ready: cycle %0d got %b want %b", c, req_ready, m_g); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL rr_valid: cycle %0d got %b want %b", c, rsp_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (rsp_data !== exp_q[0].data || rsp_id !== exp_q[0].id || rsp_carry !== exp_q[0].carry) begin
          errors++; $display("FAIL rr_result: cycle %0d got d=%h id=%0d c=%b want d=%h id=%0d c=%b", c, rsp_data, rsp_id, rsp_carry, exp_q[0].data, exp_q[0].id, exp_q[0].carry);
        end
      end
      advance();
      if (m_gidx >= 0 && c < 13) set_req(m_gidx, 1'b1, $urandom(), $urandom(), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_ops();
    ops_tbl = '{32'd5, 32'd14, 32'd9, 32'd9};
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) set_req(0, 1'b1, 32'd5, 32'd9, 2'(c));
      else req_valid = '0;
      predict();
      if (c >= 1 && c <= 4) begin
        checks++;
        if (rsp_data !== ops_tbl[c-1] || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin
          errors++; $display("FAIL op_%0d: got d=%0d c=%b id=%0d want d=%0d c=0 id=0", c - 1, rsp_data, rsp_carry, rsp_id, ops_tbl[c-1]);
        end
      end
      checks++; if (req_ready !== m_g) begin errors++; $display("FAIL ops_ready: cycle %0d got %b want %b", c, req_ready, m_g); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL ops_valid: cycle %0d got %b want %b", c, rsp_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (rsp_data !== exp_q[0].data || rsp_id !== exp_q[0].id || rsp_carry !== exp_q[0].carry) begin
          errors++; $display("FAIL ops_result: cycle %0d got d=%h c=%b want d=%h c=%b", c, rsp_data, rsp_carry, exp_q[0].data, exp_q[0].carry);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b1, 32'h1234_5678, 32'h0000_1111, 2'b01);
    set_req(1, 1'b0, 32'hAAAA_0001, 32'hBBBB_0001, 2'b00);
    set_req(3, 1'b0, 32'hCCCC_0003, 32'hDDDD_0003, 2'b10);
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       begin req_valid = 4'b0001; rsp_ready = 1'b0; end
        1:       req_valid = 4'b1010;
        4:       rsp_ready = 1'b1;
        5:       req_valid = 4'b1000;
        6:       req_valid = 4'b0000;
        default: ;
      endcase
      predict();
      if (c >= 1 && c <= 3) begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall: cycle %0d got %b want 0000", c, req_ready); end
      end
      if (c == 4) begin
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release: got %b want 0010", req_ready); end
      end
      if (c == 5) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hAAAA_0001) begin
          errors++; $display("FAIL drain_refill: got v=%b id=%0d d=%h want v=1 id=1 d=aaaa0001", rsp_valid, rsp_id, rsp_data);
        end
      end
      checks++; if (req_ready !== m_g) begin errors++; $display("FAIL bp_ready: cycle %0d got %b want %b", c, req_ready, m_g); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL bp_valid: cycle %0d got %b want %b", c, rsp_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (rsp_data !== exp_q[0].data || rsp_id !== exp_q[0].id || rsp_carry !== exp_q[0].carry) begin
          errors++; $display("FAIL bp_result: cycle %0d got d=%h id=%0d c=%b want d=%h id=%0d c=%b", c, rsp_data, rsp_id, rsp_carry, exp_q[0].data, exp_q[0].id, exp_q[0].carry);
        end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < R; k++) set_req(k, 1'b1, $urandom(), $urandom(), 2'b01);
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      predict();
      checks++; if (req_ready !== m_g) begin errors++; $display("FAIL ar_ready: cycle %0d got %b want %b", c, req_ready, m_g); end
      advance();
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'd0 || rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin
      errors++; $display("FAIL ar_clear: got d=%h id=%0d c=%b want 0", rsp_data, rsp_id, rsp_carry);
    end
    req_valid = 4'b1010;
    @(posedge clk); #1;
    rst = 1'b0; m_ptr = 0; m_valid = 1'b0; exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      predict();
      if (c == 0) begin
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ar_first_grant: got %b want 0010", req_ready); end
      end
      checks++; if (req_ready !== m_g) begin errors++; $display("FAIL ar_post_ready: cycle %0d got %b want %b", c, req_ready, m_g); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL ar_post_valid: cycle %0d got %b want %b", c, rsp_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (rsp_data !== exp_q[0].data || rsp_id !== exp_q[0].id || rsp_carry !== exp_q[0].carry) begin
          errors++; $display("FAIL ar_post_result: cycle %0d got d=%h id=%0d want d=%h id=%0d", c, rsp_data, rsp_id, exp_q[0].data, exp_q[0].id);
        end
      end
      advance();
      if (m_gidx >= 0) req_valid[m_gidx] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_first_add();
    test_round_robin();
    test_ops();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
